// File: rtl/vga_layer_compositor_pkg.sv
// vga_layer_compositor_pkg: VGA bus layout, alpha width and the fade blend helper
package vga_layer_compositor_pkg;
   localparam int VGA_RGB_W     = 12;
   localparam int VGA_RGB_BIT   = 0;
   localparam int VGA_HSYNC_BIT = 12;
   localparam int VGA_VSYNC_BIT = 13;
   localparam int VGA_BUS_SIZE  = 16;
   localparam int LAYER_ALPHA_W = 4;
   typedef logic [VGA_BUS_SIZE-1:0]  vga_bus_t;
   typedef logic [LAYER_ALPHA_W-1:0] alpha_t;
   localparam alpha_t ALPHA_MAX = '1;
   // Mixes one 4-bit channel of the layer over the background: (ch*a + base*(15-a)) / 15, truncating
   function automatic logic [3:0] blend_ch(input logic [3:0] ch, input logic [3:0] base, input alpha_t a);
      logic [7:0] mix;
      mix = ({4'd0, ch} * {4'd0, a} + {4'd0, base} * {4'd0, ALPHA_MAX - a}) / 8'd15;
      return mix[3:0];
   endfunction
endpackage

// File: rtl/vga_layer_compositor_prio_enc.sv
// layer_priority_enc: index of the highest set win bit plus a valid flag
module layer_priority_enc #(
   parameter int N     = 6,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     win_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);
   // later (higher) set bits override earlier ones, so the topmost layer wins; idx is 0 when nothing wins
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < N; i++) if (win_i[i]) idx_o = IDX_W'(i);
   end
   assign valid_o = |win_i;
endmodule

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: N-layer pixel compositor, frame-synchronous enables, latency 2 (optional fade: VGA_LAYER_FADE_EN)
module vga_layer_compositor
   import vga_layer_compositor_pkg::*;
#(
   parameter int N_LAYERS = 6,
   parameter int RGB_W    = VGA_RGB_W
`ifdef VGA_LAYER_FADE_EN
   ,parameter int FADE_STEP = 1
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  vga_bus_t                  vga_bus_i,
   input  logic [N_LAYERS*RGB_W-1:0] layer_rgb_i,
   input  logic [N_LAYERS-1:0]       layer_opaque_i,
   input  logic [N_LAYERS-1:0]       layer_en_i,
   output vga_bus_t                  vga_bus_o,
   output logic                      frame_tick_o,
   output logic [N_LAYERS-1:0]       active_mask_o
);
   localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
   logic                      vsync_q, frame_tick_q, boundary;
   logic [N_LAYERS-1:0]       active_mask_q, eff_en, win1_q;
   vga_bus_t                  bus1_q, bus2_q, bus2_d;
   logic [N_LAYERS*RGB_W-1:0] rgb1_q;
   logic [RGB_W-1:0]          lay [N_LAYERS];
   logic [RGB_W-1:0]          base, rgb_d;
   logic [IDX_W-1:0]          sel;
   logic                      sel_valid;

   assign boundary = vga_bus_i[VGA_VSYNC_BIT] & ~vsync_q;

   // track vsync; at each frame start latch the requested enables and pulse frame_tick one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q       <= 1'b0;
         frame_tick_q  <= 1'b0;
         active_mask_q <= '0;
      end else begin
         vsync_q      <= vga_bus_i[VGA_VSYNC_BIT];
         frame_tick_q <= boundary;
         if (boundary) active_mask_q <= layer_en_i;
      end
   end

`ifdef VGA_LAYER_FADE_EN
   localparam logic [LAYER_ALPHA_W:0] STEP = FADE_STEP[LAYER_ALPHA_W:0];
   alpha_t                 alpha_q  [N_LAYERS];
   alpha_t                 alpha1_q [N_LAYERS];
   alpha_t                 alpha_d  [N_LAYERS];
   logic [LAYER_ALPHA_W:0] alpha_up [N_LAYERS];
   for (genvar g = 0; g < N_LAYERS; g++) begin : g_fade
      assign alpha_up[g] = {1'b0, alpha_q[g]} + STEP;
      assign alpha_d[g]  = active_mask_q[g]
                           ? ((alpha_up[g] > {1'b0, ALPHA_MAX}) ? ALPHA_MAX : alpha_up[g][LAYER_ALPHA_W-1:0])
                           : (({1'b0, alpha_q[g]} < STEP) ? '0 : alpha_q[g] - STEP[LAYER_ALPHA_W-1:0]);
      assign eff_en[g]   = |alpha_q[g];
   end
   // alphas step once per frame toward the old mask; S1 keeps the alpha that went with each pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_LAYERS; i++) begin
            alpha_q[i]  <= '0;
            alpha1_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_LAYERS; i++) begin
            if (boundary) alpha_q[i] <= alpha_d[i];
            alpha1_q[i] <= alpha_q[i];
         end
      end
   end
`else
   assign eff_en = active_mask_q;
`endif

   // S1: capture bus, layer pixels and per-layer win using the mask in force for this pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus1_q <= '0;
         rgb1_q <= '0;
         win1_q <= '0;
      end else begin
         bus1_q <= vga_bus_i;
         rgb1_q <= layer_rgb_i;
         win1_q <= layer_opaque_i & eff_en;
      end
   end

   for (genvar g = 0; g < N_LAYERS; g++) begin : g_lay
      assign lay[g] = rgb1_q[g*RGB_W +: RGB_W];
   end

   layer_priority_enc #(.N(N_LAYERS), .IDX_W(IDX_W)) u_prio (
      .win_i   (win1_q),
      .idx_o   (sel),
      .valid_o (sel_valid)
   );

   assign base = bus1_q[VGA_RGB_BIT +: RGB_W];

`ifdef VGA_LAYER_FADE_EN
   // S2 colour: blend the winning layer over the background with its alpha
   always_comb begin
      rgb_d = base;
      if (sel_valid) for (int c = 0; c < 3; c++) rgb_d[c*4 +: 4] = blend_ch(lay[sel][c*4 +: 4], base[c*4 +: 4], alpha1_q[sel]);
   end
`else
   assign rgb_d = sel_valid ? lay[sel] : base;
`endif

   // S2 bus: every non-RGB field passes through untouched so timing stays aligned with colour
   always_comb begin
      bus2_d                         = bus1_q;
      bus2_d[VGA_RGB_BIT +: RGB_W]   = rgb_d;
   end

   // S2 register drives the composited output bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus2_q <= '0;
      else        bus2_q <= bus2_d;
   end

   assign vga_bus_o     = bus2_q;
   assign frame_tick_o  = frame_tick_q;
   assign active_mask_o = active_mask_q;
endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb_vga_layer_compositor: directed + randomized checks of the compositor against a frame-level model
module tb_vga_layer_compositor;
   import vga_layer_compositor_pkg::*;
   localparam int N     = 6;
   localparam int FSTEP = 5;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [15:0]     bus_in = '0;
   logic [N*12-1:0] lrgb = '0;
   logic [N-1:0]    opq = '0, en = '0;
   logic [15:0]     bus_out;
   logic            tick;
   logic [N-1:0]    mask;
   int checks = 0, errors = 0;
   logic [N*12-1:0] L  = {12'h5A5, 12'h444, 12'h333, 12'h2C2, 12'h111, 12'h0F0};
   logic [N*12-1:0] rr = '0;
   logic [15:0]     p1 = '0, ebus = '0;
   logic            etick = 1'b0, prev_vs = 1'b0;
   logic [N-1:0]    m_mask = '0;
   int              alpha [N] = '{default: 0};
   int              t6 [5] = '{0, 5, 10, 15, 15};

   always #5 clk = ~clk;

   vga_layer_compositor #(
      .N_LAYERS (N),
      .RGB_W    (12)
`ifdef VGA_LAYER_FADE_EN
      ,.FADE_STEP (FSTEP)
`endif
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .vga_bus_i      (bus_in),
      .layer_rgb_i    (lrgb),
      .layer_opaque_i (opq),
      .layer_en_i     (en),
      .vga_bus_o      (bus_out),
      .frame_tick_o   (tick),
      .active_mask_o  (mask)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [11:0] rgb, input logic hs, input logic vs);
      return {2'b00, vs, hs, rgb};
   endfunction

   // what the screen must show for one pixel given the frame's enables (and alphas)
   function automatic logic [15:0] comp(input logic [15:0] b, input logic [N*12-1:0] r, input logic [N-1:0] o);
      int w = -1;
      logic [15:0] res = b;
      for (int i = 0; i < N; i++) begin
`ifdef VGA_LAYER_FADE_EN
         if (o[i] && alpha[i] != 0) w = i;
`else
         if (o[i] && m_mask[i]) w = i;
`endif
      end
      if (w >= 0) begin
`ifdef VGA_LAYER_FADE_EN
         for (int c = 0; c < 3; c++) begin
            int ch = int'(r[w*12 + c*4 +: 4]);
            int bc = int'(b[c*4 +: 4]);
            res[c*4 +: 4] = 4'((ch * alpha[w] + bc * (15 - alpha[w])) / 15);
         end
`else
         res[11:0] = r[w*12 +: 12];
`endif
      end
      return res;
   endfunction

   // frame-level model: output is the composite of the input two edges back; enables (and alphas) move at vsync rise
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1      <= '0;
         ebus    <= '0;
         etick   <= 1'b0;
         m_mask  <= '0;
         prev_vs <= 1'b0;
         for (int i = 0; i < N; i++) alpha[i] <= 0;
      end else begin
         ebus    <= p1;
         p1      <= comp(bus_in, lrgb, opq);
         etick   <= bus_in[VGA_VSYNC_BIT] && !prev_vs;
         prev_vs <= bus_in[VGA_VSYNC_BIT];
         if (bus_in[VGA_VSYNC_BIT] && !prev_vs) begin
            m_mask <= en;
            for (int i = 0; i < N; i++)
               alpha[i] <= m_mask[i] ? ((alpha[i] + FSTEP > 15) ? 15 : alpha[i] + FSTEP)
                                     : ((alpha[i] < FSTEP) ? 0 : alpha[i] - FSTEP);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model_bus", 32'(bus_out), 32'(ebus));
         chk("model_tick", 32'(tick), 32'(etick));
         chk("model_mask", 32'(mask), 32'(m_mask));
      end
   end

   task automatic drv(input logic [15:0] b, input logic [N*12-1:0] r, input logic [N-1:0] o, input logic [N-1:0] e);
      @(posedge clk);
      #2;
      bus_in = b;
      lrgb   = r;
      opq    = o;
      en     = e;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step_chk(input string nm, input logic [11:0] exp);
      @(posedge clk);
      @(negedge clk);
      chk(nm, 32'(bus_out[11:0]), 32'(exp));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_async_bus", 32'(bus_out), 32'h0);
      chk("rst_async_mask", 32'(mask), 32'h0);
      chk("rst_async_tick", 32'(tick), 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rel_mask", 32'(mask), 32'h0);
      chk("rst_rel_bus", 32'(bus_out), 32'h0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_bus", 32'(bus_out), 32'h0);
      chk("reset_mask", 32'(mask), 32'h0);
      chk("reset_tick", 32'(tick), 32'h0);
      // all layers requested before the first vsync rise: nothing shows yet
      drv(mk(12'h123, 1'b0, 1'b0), L, 6'h3F, 6'h3F);
      settle();
      chk("t1_pre_rgb", 32'(bus_out[11:0]), 32'h123);
      drv(mk(12'h123, 1'b0, 1'b1), L, 6'h3F, 6'h3F);
      @(posedge clk);
      @(negedge clk);
      chk("t1_tick", 32'(tick), 32'h1);
      chk("t1_mask", 32'(mask), 32'h3F);
      @(posedge clk);
      @(negedge clk);
      chk("t1_tick_off", 32'(tick), 32'h0);
      chk("t1_edge_pix", 32'(bus_out[11:0]), 32'h123);
`ifndef VGA_LAYER_FADE_EN
      // layers 2 and 5 opaque: 5 wins; dropping en[5] mid-frame is invisible until the next frame
      drv(mk(12'h123, 1'b0, 1'b1), L, 6'b100100, 6'h3F);
      settle();
      chk("t2_top5", 32'(bus_out[11:0]), 32'h5A5);
      drv(mk(12'h123, 1'b0, 1'b1), L, 6'b100100, 6'h1F);
      settle();
      chk("t2_hold5", 32'(bus_out[11:0]), 32'h5A5);
      drv(mk(12'h123, 1'b0, 1'b0), L, 6'b100100, 6'h1F);
      settle();
      chk("t2_hold5_b", 32'(bus_out[11:0]), 32'h5A5);
      drv(mk(12'h123, 1'b0, 1'b1), L, 6'b100100, 6'h1F);
      step_chk("t2_prev_pix", 12'h5A5);
      step_chk("t2_edge_old", 12'h5A5);
      step_chk("t2_layer2", 12'h2C2);
      chk("t2_mask", 32'(mask), 32'h1F);
      // enables change on the very edge cycle: captured, but that pixel still uses the old mask
      drv(mk(12'h123, 1'b0, 1'b0), L, 6'b100100, 6'h1F);
      settle();
      drv(mk(12'h123, 1'b0, 1'b1), L, 6'b100100, 6'h3F);
      drv(mk(12'h123, 1'b0, 1'b1), L, 6'b100100, 6'h00);
      @(negedge clk);
      chk("t4_mask", 32'(mask), 32'h3F);
      step_chk("t4_edge_old", 12'h2C2);
      step_chk("t4_new", 12'h5A5);
`endif
      // nothing wins: background and sync bits come out exactly two edges later
      drv(mk(12'h0A5, 1'b1, 1'b0), L, 6'h00, 6'h3F);
      settle();
      chk("t3_rgb", 32'(bus_out[11:0]), 32'h0A5);
      chk("t3_hs", 32'(bus_out[VGA_HSYNC_BIT]), 32'h1);
      drv(mk(12'h0A5, 1'b0, 1'b1), L, 6'h00, 6'h3F);
      @(posedge clk);
      @(negedge clk);
      chk("t3_hs_d1", 32'(bus_out[VGA_HSYNC_BIT]), 32'h1);
      chk("t3_vs_d1", 32'(bus_out[VGA_VSYNC_BIT]), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("t3_hs_d2", 32'(bus_out[VGA_HSYNC_BIT]), 32'h0);
      chk("t3_vs_d2", 32'(bus_out[VGA_VSYNC_BIT]), 32'h1);
      // randomized frames with a reset dropped in mid-line
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) rr[i*12 +: 12] = 12'($urandom);
         drv({2'($urandom), (k % 60) >= 54, (k % 12) == 0, 12'($urandom)}, rr, N'($urandom), N'($urandom));
         if (k == 1500) do_reset();
      end
`ifdef VGA_LAYER_FADE_EN
      // white layer 0 fading in over black: R steps 0,5,10,15 per frame then holds
      do_reset();
      drv(mk(12'h000, 1'b0, 1'b0), {60'h0, 12'hFFF}, 6'h01, 6'h01);
      settle();
      for (int f = 0; f < 5; f++) begin
         drv(mk(12'h000, 1'b0, 1'b1), {60'h0, 12'hFFF}, 6'h01, 6'h01);
         drv(mk(12'h000, 1'b0, 1'b0), {60'h0, 12'hFFF}, 6'h01, 6'h01);
         repeat (4) @(posedge clk);
         @(negedge clk);
         chk("t6_red", 32'(bus_out[11:8]), 32'(t6[f]));
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
